// File: rtl/pb_conditioner_if.sv
// rtl/pb_conditioner_if.sv - pushbutton pin and conditioned outputs
// master drives the raw pin, slave is the conditioner.
interface pb_conditioner_if;
  logic pb_i;
  logic pb_o;
  logic pb_level;
  logic pb_long;

  modport master (output pb_i, input pb_o, input pb_level, input pb_long);
  modport slave  (input pb_i, output pb_o, output pb_level, output pb_long);
endinterface

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - pushbutton synchronizer, debouncer and press pulse
// Long-press pulse is built only when PB_LONGPRESS_EN is defined.
module pb_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = 20000000
) (
  input logic             clk,
  input logic             rst,
  pb_conditioner_if.slave bus
);
  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             p;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;

  assign p = bus.pb_i ^ ACTIVE_LOW;

  // The count only survives while every sample disagrees with the debounced level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= p;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.pb_o     = pulse_q;
  assign bus.pb_level = level_q;

`ifdef PB_LONGPRESS_EN
  localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              long_q;
  logic              long_d;

  // Saturation at HOLD_MAX is what limits the pulse to once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_d == HOLD_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign bus.pb_long = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_CYCLES;
  assign bus.pb_long     = 1'b0;
`endif
endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
Front end for the stopwatch pushbutton. It takes the raw, asynchronous, bouncing button input and produces a clean one-cycle press pulse, pb_o, which the stopwatch control FSM consumes as its advance event. The chain is: 2-flop synchronizer, then stable-time debouncer, then rising-edge pulse generator. One instance sits per physical button, between the board pin and the FSM.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive clk cycles the synchronized input must differ from the debounced level before the level flips; legal range >= 1.
ACTIVE_LOW, 0, 1 = pressed button drives pb_i low; the input is inverted before the synchronizer.
LONG_CYCLES, 20000000, cycles of held debounced press before pb_long fires; used only with PB_LONGPRESS_EN.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
pb_i  input  1  raw button pin, asynchronous to clk.
pb_o  output  1  one-cycle pulse per debounced press.
pb_level  output  1  debounced pressed level; 1 = pressed.
pb_long  output  1  one-cycle long-press pulse; constant 0 without PB_LONGPRESS_EN.

Behaviour:
- Reset and clocking: one clock (clk). Reset rst is synchronous and active-high. While rst=1 at a posedge, the following all clear to 0: both sync flops, debounce counter, pb_level, pb_o, pb_long, and the hold counter.
- Input normalisation: p = pb_i ^ ACTIVE_LOW. Sync chain is s1 <= p; s2 <= s1. Only s2 is used downstream.
- Debounce counter width is CNT_W = $clog2(DEBOUNCE_CYCLES+1). Each cycle:
  - s2 == pb_level: counter <= 0.
  - s2 != pb_level and counter == DEBOUNCE_CYCLES-1: pb_level <= s2 and counter <= 0.
  - otherwise: counter <= counter+1.
- Any single-cycle return of s2 to pb_level restarts the count. A glitch or bounce train where no run of differing samples is DEBOUNCE_CYCLES long produces no level change.
- pb_o is registered and equals 1 exactly in the cycle where pb_level first reads 1 after reading 0. It is never high two consecutive cycles. Release (1 to 0) produces no pulse.
- Latency: p steady high before posedge E0 gives s2=1 after E1. pb_level and pb_o are first high after posedge E1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges from the first sampling edge. Release latency is the same, with no pulse.
- Release and press debounce are symmetric and use the same count.
- Reset mid-debounce discards partial counts. A button held through reset deassertion is treated as a new press: pb_o fires DEBOUNCE_CYCLES+2 cycles after rst falls. This is intended, and the FSM tolerates it.
- Reset asserted in the cycle pb_o would rise: reset wins, no pulse.
- No counter ever wraps. The debounce counter never exceeds DEBOUNCE_CYCLES-1, and the hold counter saturates.

Optional Feature:
Macro PB_LONGPRESS_EN.
- Defined: a hold counter (width $clog2(LONG_CYCLES+1)) clears whenever pb_level=0. While pb_level=1 it increments and saturates at LONG_CYCLES. pb_long is a registered pulse in the cycle the counter reaches LONG_CYCLES, once per press. A new pulse requires a release then a re-press.
- Not defined: no hold counter is built, pb_long is tied to 0, and LONG_CYCLES is ignored.

Test Plan:
1. DEBOUNCE_CYCLES=4, rst high 3 cycles then low, pb_i=0 -> pb_o, pb_level, pb_long all 0 throughout 20 cycles.
2. DEBOUNCE_CYCLES=4, pb_i rises cleanly and is held 20 cycles -> pb_o high exactly one cycle, 6 edges after the first sampling edge; pb_level stays 1.
3. DEBOUNCE_CYCLES=4, pb_i toggles 1,0,1,1,0,1,1,1,0 per cycle then holds 0 -> pb_o never asserts, pb_level stays 0.
4. DEBOUNCE_CYCLES=4, press held, then release with 3-cycle bounce then steady 0 -> pb_level falls 6 edges after steady 0 begins, with no pb_o on release; a second clean press gives a second single pb_o.
5. DEBOUNCE_CYCLES=4, pb_i=1 held while rst pulses high 2 cycles mid-count and again after pb_level=1 -> counts discard; pb_o fires once, 6 edges after the final rst deassertion.
6. PB_LONGPRESS_EN defined, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, press held 30 cycles -> pb_o once, then pb_long once 10 cycles after pb_level rose, no repeat; without the macro, pb_long stays 0.
